mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Memory-stage load/store unit. It consumes the execute-stage result (i_exu_dout) as the effective address, plus rs2 store data and funct3. It runs a valid/ready data-bus transaction, aligns and sign/zero-extends load data, and stalls the pipeline until the access completes. It detects misaligned and unsupported accesses without touching the bus, and reports bus errors and bus timeouts as access faults.

Parameters:
ADDR_WIDTH, 32, width of effective address and o_dbus_addr
TIMEOUT_CYCLES, 256, max cycles in REQ+WAIT_RSP before fault; must be >=2

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  synchronous active-low reset
i_valid  input  1  EX/MEM register holds a valid instruction
i_is_load  input  1  instruction is a load
i_is_store  input  1  instruction is a store
i_funct3  input  3  RV32 funct3 (access size/signedness)
i_exu_dout  input  ADDR_WIDTH  effective address from execute stage
i_rs2_rd_data  input  32  store data
o_stall  output  1  hold IF..MEM stages this cycle
o_done  output  1  one-cycle pulse: access finished without fault
o_mem_dout  output  32  extended load result (registered)
o_misaligned  output  1  one-cycle pulse: misaligned or unsupported funct3
o_access_fault  output  1  one-cycle pulse: bus error or timeout
o_dbus_req_valid  output  1  request valid
i_dbus_req_ready  input  1  request accepted
o_dbus_addr  output  ADDR_WIDTH  word-aligned address (low 2 bits 0)
o_dbus_we  output  1  1=write
o_dbus_wstrb  output  4  byte strobes
o_dbus_wdata  output  32  lane-replicated store data
i_dbus_rsp_valid  input  1  response valid
i_dbus_rsp_err  input  1  response carries error (qualified by rsp_valid)
i_dbus_rsp_rdata  input  32  read data word
o_dbus_rsp_ready  output  1  ready for response

Behaviour:
- start = i_valid & (i_is_load | i_is_store); both set is treated as store.
- Legal funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store 000 SB, 001 SH, 010 SW. Any other value is unsupported.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
  - IDLE, start & (misaligned|unsupported): o_misaligned=1 this cycle (combinational), no stall, no bus request, stay IDLE.
  - IDLE, start & legal: register addr/we/wstrb/wdata/funct3/addr[1:0]; o_stall=1 (combinational); next state REQ.
  - REQ: o_dbus_req_valid=1 with registered fields held stable; when i_dbus_req_ready=1, go to WAIT_RSP.
  - WAIT_RSP: o_dbus_rsp_ready=1. When i_dbus_rsp_valid=1 and err=0, register o_mem_dout (loads only; stores leave it unchanged) and go to DONE. When i_dbus_rsp_valid=1 and err=1, go to DONE with a fault flag set.
  - DONE: o_stall=0. Pulse o_done, or o_access_fault if the fault flag is set, never both. Return to IDLE. New starts are ignored in DONE, because the inputs still show the retiring instruction.
- o_stall = (IDLE & start & legal) | REQ | WAIT_RSP.
- Latency with zero-wait bus (ready=1 in REQ, rsp_valid in the first WAIT_RSP cycle): start cycle T, REQ T+1, WAIT_RSP T+2, DONE T+3. Stall lasts 3 cycles.
- Timeout counter: cleared on entry to REQ, increments each cycle in REQ/WAIT_RSP. When it reaches TIMEOUT_CYCLES-1 without completion: go to DONE with fault flag and drop req_valid/rsp_ready. Responses arriving later are ignored, since rsp_ready=0 outside WAIT_RSP.
- Store encoding, with off=addr[1:0]:
  - SB: wstrb=0001<<off, wdata={4{rs2[7:0]}}.
  - SH: wstrb=0011<<off, wdata={2{rs2[15:0]}}.
  - SW: wstrb=1111, wdata=rs2.
- Loads: wstrb=0000, we=0. Extension from rdata selects the byte or half at off: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
- Reset (i_rst_n=0 at clock edge), including mid-transaction:
  - State returns to IDLE; all outputs 0; o_mem_dout=0; timeout counter and fault flag cleared.
  - The bus interconnect must tolerate an abandoned request.
- All pulses are exactly one cycle. o_dbus_addr/we/wstrb/wdata reset to 0 and change only on acceptance in IDLE.

Test Plan:
- LW addr 0x100, bus returns 0xDEADBEEF immediately -> req at T+1 with addr 0x100, wstrb 0000; o_done at T+3; o_mem_dout=0xDEADBEEF; o_stall high T..T+2 only.
- LB addr 0x103, rdata 0x80FF_0000 -> o_mem_dout=0xFFFFFF80. Same access as LBU -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SH addr 0x206, rs2=0x1234ABCD -> o_dbus_addr 0x204, wstrb 1100, wdata 0xABCDABCD, we=1; SB addr 0x201 -> wstrb 0010, wdata 0xCDCDCDCD.
- LW addr 0x102, then SH addr 0x301, then funct3=011 load -> each gives a single o_misaligned pulse, req_valid never asserted, o_stall 0.
- req_ready held low 3 cycles, then rsp_err=1 -> req_valid held stable 4 cycles; o_access_fault pulse, no o_done. With TIMEOUT_CYCLES=8 and no response ever -> fault pulse exactly 8 cycles after entering REQ.
- Reset asserted in WAIT_RSP, rsp_valid arrives the next cycle -> all outputs 0, rsp ignored, no o_done; a fresh LW afterwards completes normally.

Source files
------------

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one valid/ready data-bus access per instruction, with load extension and fault detection.
// Latency: start T, REQ T+1, WAIT_RSP T+2, DONE T+3 on a zero-wait bus; misaligned or unsupported accesses resolve in T.
// Backpressure: holds req_valid until req_ready and waits for rsp_valid, stalling IF..MEM; the watchdog bounds the wait.
module mem_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic                  i_is_load,
    input  logic                  i_is_store,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH-1:0] i_exu_dout,
    input  logic [31:0]           i_rs2_rd_data,
    output logic                  o_stall,
    output logic                  o_done,
    output logic [31:0]           o_mem_dout,
    output logic                  o_misaligned,
    output logic                  o_access_fault,
    output logic                  o_dbus_req_valid,
    input  logic                  i_dbus_req_ready,
    output logic [ADDR_WIDTH-1:0] o_dbus_addr,
    output logic                  o_dbus_we,
    output logic [3:0]            o_dbus_wstrb,
    output logic [31:0]           o_dbus_wdata,
    input  logic                  i_dbus_rsp_valid,
    input  logic                  i_dbus_rsp_err,
    input  logic [31:0]           i_dbus_rsp_rdata,
    output logic                  o_dbus_rsp_ready
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [3:0]            wstrb;
        logic [31:0]           wdata;
    } dbus_req_t;

    state_t          state_q, state_d;
    dbus_req_t       req_q, new_req;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic [31:0]     mem_dout_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            fault_q, fault_d;

    logic            start;
    logic            is_st;
    logic [1:0]      off;
    logic            legal_f3;
    logic            misal;
    logic            bad;
    logic            cap_en;
    logic            ld_en;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_ext;

    // Gating with reset keeps every output low while reset is held.
    assign start = i_rst_n & i_valid & (i_is_load | i_is_store);
    assign is_st = i_is_store;
    assign off   = i_exu_dout[1:0];

    always_comb begin
        legal_f3 = 1'b0;
        misal    = 1'b0;
        if (is_st) begin
            case (i_funct3)
                3'b000:  legal_f3 = 1'b1;
                3'b001:  begin legal_f3 = 1'b1; misal = off[0]; end
                3'b010:  begin legal_f3 = 1'b1; misal = |off;   end
                default: legal_f3 = 1'b0;
            endcase
        end else begin
            case (i_funct3)
                3'b000, 3'b100: legal_f3 = 1'b1;
                3'b001, 3'b101: begin legal_f3 = 1'b1; misal = off[0]; end
                3'b010:         begin legal_f3 = 1'b1; misal = |off;   end
                default:        legal_f3 = 1'b0;
            endcase
        end
    end

    assign bad = ~legal_f3 | misal;

    always_comb begin
        new_req.addr  = {i_exu_dout[ADDR_WIDTH-1:2], 2'b00};
        new_req.we    = is_st;
        new_req.wstrb = 4'b0000;
        new_req.wdata = 32'h0;
        if (is_st) begin
            case (i_funct3[1:0])
                2'b00: begin
                    new_req.wstrb = 4'b0001 << off;
                    new_req.wdata = {4{i_rs2_rd_data[7:0]}};
                end
                2'b01: begin
                    new_req.wstrb = 4'b0011 << off;
                    new_req.wdata = {2{i_rs2_rd_data[15:0]}};
                end
                default: begin
                    new_req.wstrb = 4'b1111;
                    new_req.wdata = i_rs2_rd_data;
                end
            endcase
        end
    end

    // Lane select uses the offset captured at start; the bus returns the whole aligned word.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = i_dbus_rsp_rdata[7:0];
            2'd1:    ld_byte = i_dbus_rsp_rdata[15:8];
            2'd2:    ld_byte = i_dbus_rsp_rdata[23:16];
            default: ld_byte = i_dbus_rsp_rdata[31:24];
        endcase
        ld_half = off_q[1] ? i_dbus_rsp_rdata[31:16] : i_dbus_rsp_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = i_dbus_rsp_rdata;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        fault_d          = fault_q;
        cnt_d            = cnt_q;
        cap_en           = 1'b0;
        ld_en            = 1'b0;
        o_stall          = 1'b0;
        o_done           = 1'b0;
        o_access_fault   = 1'b0;
        o_misaligned     = 1'b0;
        o_dbus_req_valid = 1'b0;
        o_dbus_rsp_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                fault_d = 1'b0;
                if (start) begin
                    if (bad) begin
                        o_misaligned = 1'b1;
                    end else begin
                        o_stall = 1'b1;
                        cap_en  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                o_stall          = 1'b1;
                o_dbus_req_valid = 1'b1;
                cnt_d            = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_MAX) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else if (i_dbus_req_ready) begin
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                o_stall          = 1'b1;
                o_dbus_rsp_ready = 1'b1;
                cnt_d            = cnt_q + CNT_W'(1);
                if (i_dbus_rsp_valid) begin
                    fault_d = i_dbus_rsp_err;
                    ld_en   = ~i_dbus_rsp_err & ~req_q.we;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                // Inputs still show the retiring instruction here, so no new start.
                o_done         = ~fault_q;
                o_access_fault = fault_q;
                state_d        = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
            req_q      <= '0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            mem_dout_q <= 32'h0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            if (cap_en) begin
                req_q    <= new_req;
                funct3_q <= i_funct3;
                off_q    <= off;
            end
            if (ld_en) begin
                mem_dout_q <= ld_ext;
            end
        end
    end

    assign o_dbus_addr  = req_q.addr;
    assign o_dbus_we    = req_q.we;
    assign o_dbus_wstrb = req_q.wstrb;
    assign o_dbus_wdata = req_q.wdata;
    assign o_mem_dout   = mem_dout_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: stimulus pushes expected pulses and bus requests, monitors pop and compare.
module tb_mem_lsu;

    localparam int AW = 32;
    localparam int TO = 8;
    localparam logic [2:0] K_DONE  = 3'b100;
    localparam logic [2:0] K_FAULT = 3'b010;
    localparam logic [2:0] K_MIS   = 3'b001;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_valid;
    logic          i_is_load;
    logic          i_is_store;
    logic [2:0]    i_funct3;
    logic [AW-1:0] i_exu_dout;
    logic [31:0]   i_rs2_rd_data;
    logic          o_stall;
    logic          o_done;
    logic [31:0]   o_mem_dout;
    logic          o_misaligned;
    logic          o_access_fault;
    logic          o_dbus_req_valid;
    logic          i_dbus_req_ready;
    logic [AW-1:0] o_dbus_addr;
    logic          o_dbus_we;
    logic [3:0]    o_dbus_wstrb;
    logic [31:0]   o_dbus_wdata;
    logic          i_dbus_rsp_valid;
    logic          i_dbus_rsp_err;
    logic [31:0]   i_dbus_rsp_rdata;
    logic          o_dbus_rsp_ready;

    always #5 i_clk = ~i_clk;

    mem_lsu #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_funct3(i_funct3),
        .i_exu_dout(i_exu_dout), .i_rs2_rd_data(i_rs2_rd_data),
        .o_stall(o_stall), .o_done(o_done), .o_mem_dout(o_mem_dout),
        .o_misaligned(o_misaligned), .o_access_fault(o_access_fault),
        .o_dbus_req_valid(o_dbus_req_valid), .i_dbus_req_ready(i_dbus_req_ready),
        .o_dbus_addr(o_dbus_addr), .o_dbus_we(o_dbus_we), .o_dbus_wstrb(o_dbus_wstrb),
        .o_dbus_wdata(o_dbus_wdata), .i_dbus_rsp_valid(i_dbus_rsp_valid),
        .i_dbus_rsp_err(i_dbus_rsp_err), .i_dbus_rsp_rdata(i_dbus_rsp_rdata),
        .o_dbus_rsp_ready(o_dbus_rsp_ready)
    );

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] dout;
        string       name;
    } ev_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        string       name;
    } rq_t;

    ev_t         ev_q[$];
    rq_t         rq_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] hold_dout = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    ev_t mon_e;
    rq_t mon_r;
    always @(negedge i_clk) begin
        if (o_done || o_access_fault || o_misaligned) begin
            if (ev_q.size() == 0) begin
                check("unexpected_pulse", {61'h0, o_done, o_access_fault, o_misaligned}, 64'h0);
            end else begin
                mon_e = ev_q.pop_front();
                check({mon_e.name, "_kind"}, {61'h0, o_done, o_access_fault, o_misaligned}, {61'h0, mon_e.kind});
                check({mon_e.name, "_dout"}, {32'h0, o_mem_dout}, {32'h0, mon_e.dout});
            end
        end
        if (o_dbus_req_valid && i_dbus_req_ready) begin
            if (rq_q.size() == 0) begin
                check("unexpected_req", {32'h0, o_dbus_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_r = rq_q.pop_front();
                check({mon_r.name, "_req"}, {o_dbus_addr, 27'h0, o_dbus_we, o_dbus_wstrb},
                      {mon_r.addr, 27'h0, mon_r.we, mon_r.wstrb});
                if (mon_r.we) check({mon_r.name, "_wdata"}, {32'h0, o_dbus_wdata}, {32'h0, mon_r.wdata});
            end
        end
    end

    // Entered and left just after a rising edge; acts as the bus target for one instruction.
    task automatic run_op(input string name, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input int rdy_dly, input int rsp_dly, input logic give_rsp,
                          input logic [31:0] rdata, input logic err,
                          input logic [2:0] exp_kind, input logic [31:0] exp_dout,
                          input logic [31:0] exp_addr, input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                          input int exp_stall, input int exp_end, input int exp_reqc);
        ev_t e;
        rq_t r;
        int cyc, stall_n, req_n, wait_n, end_cyc;
        logic seen, unstable;
        logic [31:0] a0, d0;
        logic [3:0] s0;
        logic w0;
        if (exp_kind == K_DONE && ld && !st) hold_dout = exp_dout;
        e.kind = exp_kind; e.dout = hold_dout; e.name = name;
        ev_q.push_back(e);
        if (exp_reqc > 0 && rdy_dly < exp_reqc) begin
            r.addr = exp_addr; r.we = st; r.wstrb = exp_wstrb; r.wdata = exp_wdata; r.name = name;
            rq_q.push_back(r);
        end
        i_valid = 1'b1; i_is_load = ld; i_is_store = st; i_funct3 = f3;
        i_exu_dout = addr; i_rs2_rd_data = rs2;
        i_dbus_rsp_rdata = rdata; i_dbus_rsp_err = err;
        cyc = 0; stall_n = 0; req_n = 0; wait_n = 0; end_cyc = -1;
        seen = 1'b0; unstable = 1'b0;
        a0 = '0; d0 = '0; s0 = '0; w0 = 1'b0;
        while (!seen && cyc < 40) begin
            i_dbus_req_ready = o_dbus_req_valid && (req_n >= rdy_dly);
            i_dbus_rsp_valid = o_dbus_rsp_ready && give_rsp && (wait_n >= rsp_dly);
            @(negedge i_clk);
            if (o_stall) stall_n++;
            if (o_dbus_req_valid) begin
                if (req_n == 0) begin
                    a0 = o_dbus_addr; d0 = o_dbus_wdata; s0 = o_dbus_wstrb; w0 = o_dbus_we;
                end else if (a0 !== o_dbus_addr || d0 !== o_dbus_wdata || s0 !== o_dbus_wstrb || w0 !== o_dbus_we) begin
                    unstable = 1'b1;
                end
                req_n++;
            end
            if (o_dbus_rsp_ready) wait_n++;
            if (o_done || o_access_fault || o_misaligned) begin
                seen = 1'b1;
                end_cyc = cyc;
            end
            @(posedge i_clk);
            #1;
            cyc++;
        end
        i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
        i_dbus_req_ready = 1'b0; i_dbus_rsp_valid = 1'b0; i_dbus_rsp_err = 1'b0;
        check({name, "_completed"}, {63'h0, seen}, 64'h1);
        check({name, "_end_cycle"}, 64'(end_cyc), 64'(exp_end));
        check({name, "_stall_cycles"}, 64'(stall_n), 64'(exp_stall));
        check({name, "_req_cycles"}, 64'(req_n), 64'(exp_reqc));
        check({name, "_req_stable"}, {63'h0, unstable}, 64'h0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {58'h0, o_stall, o_done, o_access_fault, o_misaligned, o_dbus_req_valid, o_dbus_rsp_ready}, 64'h0);
        check({name, "_bus"}, {27'h0, o_dbus_we, o_dbus_wstrb, o_dbus_addr}, 64'h0);
        check({name, "_wdata"}, {32'h0, o_dbus_wdata}, 64'h0);
        check({name, "_mem_dout"}, {32'h0, o_mem_dout}, 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rq_t r;
        i_rst_n = 1'b0; i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
        i_funct3 = 3'b000; i_exu_dout = '0; i_rs2_rd_data = '0;
        i_dbus_req_ready = 1'b0; i_dbus_rsp_valid = 1'b0; i_dbus_rsp_err = 1'b0; i_dbus_rsp_rdata = '0;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(negedge i_clk);
        check_all_zero("reset");
        @(posedge i_clk);
        #1;

        //     name          ld    st    f3      addr          rs2           rdy rsp give rdata         err   kind     dout          req addr      strb     wdata         stall end reqc
        run_op("lw",        1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        0,  0, 1'b1, 32'hDEAD_BEEF, 1'b0, K_DONE,  32'hDEAD_BEEF, 32'h0000_0100, 4'b0000, 32'h0,        3, 3, 1);
        run_op("lb",        1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        0,  0, 1'b1, 32'h80FF_0000, 1'b0, K_DONE,  32'hFFFF_FF80, 32'h0000_0100, 4'b0000, 32'h0,        3, 3, 1);
        run_op("lbu",       1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        0,  0, 1'b1, 32'h80FF_0000, 1'b0, K_DONE,  32'h0000_0080, 32'h0000_0100, 4'b0000, 32'h0,        3, 3, 1);
        run_op("lh",        1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        0,  0, 1'b1, 32'h80FF_0000, 1'b0, K_DONE,  32'hFFFF_80FF, 32'h0000_0100, 4'b0000, 32'h0,        3, 3, 1);
        run_op("lhu",       1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        0,  0, 1'b1, 32'h80FF_0000, 1'b0, K_DONE,  32'h0000_80FF, 32'h0000_0100, 4'b0000, 32'h0,        3, 3, 1);
        run_op("lb_pos",    1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        0,  0, 1'b1, 32'h80FF_7F01, 1'b0, K_DONE,  32'h0000_007F, 32'h0000_0100, 4'b0000, 32'h0,        3, 3, 1);
        run_op("sh",        1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'h1234_ABCD, 0, 0, 1'b1, 32'h0,         1'b0, K_DONE,  32'h0,         32'h0000_0204, 4'b1100, 32'hABCD_ABCD, 3, 3, 1);
        run_op("sb",        1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_ABCD, 0, 0, 1'b1, 32'h0,         1'b0, K_DONE,  32'h0,         32'h0000_0200, 4'b0010, 32'hCDCD_CDCD, 3, 3, 1);
        run_op("sw",        1'b0, 1'b1, 3'b010, 32'h0000_0208, 32'hCAFE_F00D, 0, 0, 1'b1, 32'h0,         1'b0, K_DONE,  32'h0,         32'h0000_0208, 4'b1111, 32'hCAFE_F00D, 3, 3, 1);
        run_op("ld_st_both",1'b1, 1'b1, 3'b000, 32'h0000_020B, 32'h0000_00A5, 0, 0, 1'b1, 32'h5555_5555, 1'b0, K_DONE,  32'h0,         32'h0000_0208, 4'b1000, 32'hA5A5_A5A5, 3, 3, 1);
        run_op("lw_mis",    1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        0,  0, 1'b1, 32'h0,         1'b0, K_MIS,   32'h0,         32'h0,         4'b0000, 32'h0,        0, 0, 0);
        run_op("sh_mis",    1'b0, 1'b1, 3'b001, 32'h0000_0301, 32'h0,        0,  0, 1'b1, 32'h0,         1'b0, K_MIS,   32'h0,         32'h0,         4'b0000, 32'h0,        0, 0, 0);
        run_op("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        0,  0, 1'b1, 32'h0,         1'b0, K_MIS,   32'h0,         32'h0,         4'b0000, 32'h0,        0, 0, 0);
        run_op("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h0000_0200, 32'h0,        0,  0, 1'b1, 32'h0,         1'b0, K_MIS,   32'h0,         32'h0,         4'b0000, 32'h0,        0, 0, 0);
        run_op("lhu_mis",   1'b1, 1'b0, 3'b101, 32'h0000_0103, 32'h0,        0,  0, 1'b1, 32'h0,         1'b0, K_MIS,   32'h0,         32'h0,         4'b0000, 32'h0,        0, 0, 0);
        run_op("err_late",  1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0,        3,  0, 1'b1, 32'h1111_1111, 1'b1, K_FAULT, 32'h0,         32'h0000_0400, 4'b0000, 32'h0,        6, 6, 4);
        run_op("to_req",    1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0,        99, 0, 1'b0, 32'h0,         1'b0, K_FAULT, 32'h0,         32'h0000_0404, 4'b0000, 32'h0,        9, 9, 8);
        run_op("to_rsp",    1'b1, 1'b0, 3'b010, 32'h0000_0408, 32'h0,        0,  0, 1'b0, 32'h0,         1'b0, K_FAULT, 32'h0,         32'h0000_0408, 4'b0000, 32'h0,        9, 9, 1);
        run_op("sw_slow",   1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h1122_3344, 1, 2, 1'b1, 32'h0,         1'b0, K_DONE,  32'h0,         32'h0000_0300, 4'b1111, 32'h1122_3344, 6, 6, 2);

        // Reset while waiting for the response; the late response must be ignored.
        r.addr = 32'h0000_0600; r.we = 1'b0; r.wstrb = 4'b0000; r.wdata = 32'h0; r.name = "rst_abort";
        rq_q.push_back(r);
        i_valid = 1'b1; i_is_load = 1'b1; i_funct3 = 3'b010; i_exu_dout = 32'h0000_0600;
        @(posedge i_clk);
        #1 i_dbus_req_ready = 1'b1;
        @(posedge i_clk);
        #1 i_dbus_req_ready = 1'b0;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        i_valid = 1'b0; i_is_load = 1'b0;
        i_dbus_rsp_valid = 1'b1; i_dbus_rsp_rdata = 32'hFFFF_FFFF;
        @(negedge i_clk);
        check_all_zero("after_rst");
        @(posedge i_clk);
        #1 i_dbus_rsp_valid = 1'b0;
        @(negedge i_clk);
        check_all_zero("after_rst_rsp");
        hold_dout = 32'h0;
        @(posedge i_clk);
        #1;
        run_op("lw_post_rst", 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 0, 0, 1'b1, 32'h0123_4567, 1'b0, K_DONE, 32'h0123_4567, 32'h0000_0500, 4'b0000, 32'h0, 3, 3, 1);

        repeat (3) @(posedge i_clk);
        check("ev_queue_empty", 64'(ev_q.size()), 64'h0);
        check("rq_queue_empty", 64'(rq_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
